// File: rtl/fetch_queue_unit_if.sv
// Handshake bundle between the fetch queue, the instruction memory port and decode.
// master = fetch_queue_unit, slave = memory/decode side.
interface fetch_queue_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output inst_valid, instruction, pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  inst_valid, instruction, pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Decoupled fetch stage: in-order requests to a variable-latency imem, a DEPTH-entry
// {pc, instruction} FIFO toward decode, and redirect-driven flush of in-flight words.
module fetch_queue_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pc_jump_addr,
  input  logic                 jump_en,
  fetch_queue_unit_if.master   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  localparam entry_t RST_E = '{pc: RESET_PC, inst: 32'h0};

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        rsp_pc_q, rsp_pc_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      pending_q, pending_d;
  logic [CW-1:0]      drop_q, drop_d;

  logic [CW:0]        inflight;
  logic [31:0]        jump_tgt;
  logic               req_valid, req_fire, rsp_ok, push, pop;
  logic               jump_lsb_unused;

  assign jump_lsb_unused = ^pc_jump_addr[1:0];

  always_comb begin
    jump_tgt = {pc_jump_addr[31:2], 2'b00};
    // Credit: buffered words plus live (non-dropped) requests may not exceed DEPTH.
    inflight  = {1'b0, count_q} + {1'b0, pending_q} - {1'b0, drop_q};
    // The pending limit only bites when a redirect leaves a full window of stale
    // requests behind; it keeps the counter from wrapping.
    req_valid = rst & ~jump_en & (inflight < DEPTH_C) & (pending_q != '1);
    req_fire  = req_valid & bus.imem_req_ready;
    rsp_ok    = bus.imem_rsp_valid & (pending_q != '0);
    push      = rsp_ok & (drop_q == '0);
    pop       = (count_q != '0) & bus.inst_ready;

    mem_d      = mem_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pending_d  = pending_q;
    drop_d     = drop_q;

    if (jump_en) begin
      // A response landing in the redirect cycle is consumed here and never pushed.
      fetch_pc_d = jump_tgt;
      rsp_pc_d   = jump_tgt;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      pending_d  = pending_q - CW'(rsp_ok);
      drop_d     = pending_q - CW'(rsp_ok);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      pending_d = pending_q + CW'(req_fire) - CW'(rsp_ok);
      if (rsp_ok && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: rsp_pc_q, inst: bus.imem_rsp_data};
        wr_ptr_d        = wr_ptr_q + AW'(1);
        rsp_pc_d        = rsp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q      <= {DEPTH{RST_E}};
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      drop_q     <= '0;
    end else begin
      mem_q      <= mem_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.inst_valid     = (count_q != '0);
  assign bus.instruction    = mem_q[rd_ptr_q].inst;
  assign bus.pc             = mem_q[rd_ptr_q].pc;
endmodule
